pmpd_arbiter: RTL and testbench

Parametrised decision engine for pedal-misapplication detection. It sits between the per-channel checkers (pedal, expression, heart rate, respiration, and later channels) and the actuator/SPI status path. It fuses N detector flags with a selectable voting mode and requires the fused condition to persist before asserting `drive`. It enforces a minimum hold and a clean release, and provides a cancel override, a sticky event flag and an event counter.

---
 rtl/pmpd_pkg.sv | 24 ++
 rtl/pmpd_arbiter_if.sv | 37 +++
 rtl/pmpd_score.sv | 81 ++++++++
 rtl/pmpd_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_pmpd_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmpd_pkg.sv
// Shared types for the pedal-misapplication decision engine.
//   state_e    : arbiter FSM state encoding (3-bit, exported on the status port)
//   MODE_*     : voting-mode selector values
//   score_width: width of the weighted score for a given channel count/weight width
package pmpd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        DRIVE = 3'd2,
        HOLD  = 3'd3
    } state_e;

    localparam logic [1:0] MODE_PRIMARY_PLUS = 2'd0;
    localparam logic [1:0] MODE_MAJORITY     = 2'd1;
    localparam logic [1:0] MODE_WEIGHTED     = 2'd2;
    localparam logic [1:0] MODE_OFF          = 2'd3;

    // Sum of N_CH weights of W_WIDTH bits each never overflows this width.
    function automatic int unsigned score_width(input int unsigned n_ch, input int unsigned w_width);
        return w_width + $clog2(n_ch);
    endfunction

endpackage

// File: rtl/pmpd_arbiter_if.sv
// Detector/control bus between the channel checkers and the decision engine.
//   master: checker/host side (drives flags, config, tick, cancel, pm_clr; reads status)
//   slave : pmpd_arbiter side (reads inputs; drives drive, pm, state, score, event_cnt)
interface pmpd_arbiter_if
    import pmpd_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned W_WIDTH = 4
);
    localparam int unsigned SCORE_W = score_width(N_CH, W_WIDTH);

    logic                      tick;
    logic [N_CH-1:0]           flags;
    logic [N_CH-1:0]           ch_en;
    logic [N_CH*W_WIDTH-1:0]   weights;
    logic [SCORE_W-1:0]        threshold;
    logic [1:0]                mode;
    logic                      cancel;
    logic                      pm_clr;

    logic                      drive;
    logic                      pm;
    logic [2:0]                state;
    logic [SCORE_W-1:0]        score;
    logic [15:0]               event_cnt;

    modport master (
        output tick, flags, ch_en, weights, threshold, mode, cancel, pm_clr,
        input  drive, pm, state, score, event_cnt
    );

    modport slave (
        input  tick, flags, ch_en, weights, threshold, mode, cancel, pm_clr,
        output drive, pm, state, score, event_cnt
    );

endinterface

// File: rtl/pmpd_score.sv
// Stage-1 fusion: masks flags with enables, sums weights of active channels,
// counts active and enabled channels, and registers the threshold alongside
// so that score and threshold changes line up in the same cycle.
//   clk, rst      : clock, async active-high reset
//   flags_i       : detector flags
//   ch_en_i       : channel enables
//   weights_i     : packed per-channel weights, channel i at [i*W_WIDTH +: W_WIDTH]
//   threshold_i   : weighted-mode threshold
//   act_o         : registered flags & ch_en
//   score_o       : registered weighted sum of active channels
//   pop_o         : registered popcount of act
//   en_pop_o      : registered popcount of ch_en
//   thr_o         : registered threshold
module pmpd_score
    import pmpd_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned W_WIDTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_CH-1:0]                        flags_i,
    input  logic [N_CH-1:0]                        ch_en_i,
    input  logic [N_CH*W_WIDTH-1:0]                weights_i,
    input  logic [score_width(N_CH, W_WIDTH)-1:0]  threshold_i,
    output logic [N_CH-1:0]                        act_o,
    output logic [score_width(N_CH, W_WIDTH)-1:0]  score_o,
    output logic [$clog2(N_CH+1)-1:0]              pop_o,
    output logic [$clog2(N_CH+1)-1:0]              en_pop_o,
    output logic [score_width(N_CH, W_WIDTH)-1:0]  thr_o
);
    localparam int unsigned SCORE_W = score_width(N_CH, W_WIDTH);
    localparam int unsigned POP_W   = $clog2(N_CH + 1);

    logic [N_CH-1:0]    act_d,    act_q;
    logic [SCORE_W-1:0] score_d,  score_q;
    logic [POP_W-1:0]   pop_d,    pop_q;
    logic [POP_W-1:0]   en_pop_d, en_pop_q;
    logic [SCORE_W-1:0] thr_q;

    // Adder chain and popcounts over all channels.
    always_comb begin
        act_d    = flags_i & ch_en_i;
        score_d  = '0;
        pop_d    = '0;
        en_pop_d = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (act_d[i]) begin
                score_d = score_d + SCORE_W'(weights_i[i*W_WIDTH +: W_WIDTH]);
                pop_d   = pop_d + POP_W'(1);
            end
            if (ch_en_i[i]) begin
                en_pop_d = en_pop_d + POP_W'(1);
            end
        end
    end

    // Stage-1 registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q    <= '0;
            score_q  <= '0;
            pop_q    <= '0;
            en_pop_q <= '0;
            thr_q    <= '0;
        end else begin
            act_q    <= act_d;
            score_q  <= score_d;
            pop_q    <= pop_d;
            en_pop_q <= en_pop_d;
            thr_q    <= threshold_i;
        end
    end

    assign act_o    = act_q;
    assign score_o  = score_q;
    assign pop_o    = pop_q;
    assign en_pop_o = en_pop_q;
    assign thr_o    = thr_q;

endmodule

// File: rtl/pmpd_arbiter.sv
// Pedal-misapplication decision engine: fuses detector flags by the selected
// voting mode, requires persistence over ticks before driving the actuator,
// enforces a minimum hold plus clean release, and records events.
//   clk, rst : clock, async active-high reset
//   bus      : pmpd_arbiter_if.slave
//              in : tick, flags, ch_en, weights, threshold, mode, cancel, pm_clr
//              out: drive, pm, state, score, event_cnt (all registered)
module pmpd_arbiter
    import pmpd_pkg::*;
#(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned W_WIDTH       = 4,
    parameter int unsigned PRIMARY_CH    = 0,
    parameter int unsigned PERSIST_TICKS = 3,
    parameter int unsigned HOLD_TICKS    = 20,
    parameter int unsigned CLEAR_TICKS   = 5
) (
    input  logic          clk,
    input  logic          rst,
    pmpd_arbiter_if.slave bus
);
    localparam int unsigned SCORE_W = score_width(N_CH, W_WIDTH);
    localparam int unsigned POP_W   = $clog2(N_CH + 1);
    localparam int unsigned PERS_W  = $clog2(PERSIST_TICKS + 2);
    localparam int unsigned HOLD_W  = $clog2(HOLD_TICKS + 2);
    localparam int unsigned CLR_W   = $clog2(CLEAR_TICKS + 2);

    logic [N_CH-1:0]    act;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] thr;
    logic [POP_W-1:0]   pop;
    logic [POP_W-1:0]   en_pop;
    logic               cond_c;

    state_e             state_d, state_q;
    logic [PERS_W-1:0]  persist_d, persist_q;
    logic [HOLD_W-1:0]  hold_d, hold_q;
    logic [CLR_W-1:0]   clr_d, clr_q;
    logic               event_c;
    logic               drive_d, drive_q;
    logic               pm_d, pm_q;
    logic [15:0]        event_cnt_d, event_cnt_q;

    pmpd_score #(
        .N_CH    (N_CH),
        .W_WIDTH (W_WIDTH)
    ) u_score (
        .clk         (clk),
        .rst         (rst),
        .flags_i     (bus.flags),
        .ch_en_i     (bus.ch_en),
        .weights_i   (bus.weights),
        .threshold_i (bus.threshold),
        .act_o       (act),
        .score_o     (score),
        .pop_o       (pop),
        .en_pop_o    (en_pop),
        .thr_o       (thr)
    );

    // Fused condition from stage-1 registers under the live mode.
    always_comb begin
        cond_c = 1'b0;
        case (bus.mode)
            MODE_PRIMARY_PLUS:
                cond_c = act[PRIMARY_CH] &&
                         ((act & ~(N_CH'(1) << PRIMARY_CH)) != '0);
            MODE_MAJORITY:
                cond_c = (en_pop != '0) && ({pop, 1'b0} > {1'b0, en_pop});
            MODE_WEIGHTED:
                cond_c = (thr != '0) && (score >= thr);
            default:
                cond_c = 1'b0;
        endcase
    end

    // Next-state, counters and event strobe. Cancel/OFF override any tick.
    always_comb begin
        state_d   = state_q;
        persist_d = persist_q;
        hold_d    = hold_q;
        clr_d     = clr_q;
        event_c   = 1'b0;

        if (bus.cancel || (bus.mode == MODE_OFF)) begin
            state_d   = IDLE;
            persist_d = '0;
            hold_d    = '0;
            clr_d     = '0;
        end else if (bus.tick) begin
            case (state_q)
                IDLE: begin
                    if (cond_c) begin
                        if (PERSIST_TICKS <= 1) begin
                            state_d   = DRIVE;
                            event_c   = 1'b1;
                            persist_d = '0;
                            hold_d    = '0;
                        end else begin
                            state_d   = ARMED;
                            persist_d = PERS_W'(1);
                        end
                    end
                end
                ARMED: begin
                    if (cond_c) begin
                        if ((persist_q + PERS_W'(1)) >= PERS_W'(PERSIST_TICKS)) begin
                            state_d   = DRIVE;
                            event_c   = 1'b1;
                            persist_d = '0;
                            hold_d    = '0;
                        end else begin
                            persist_d = persist_q + PERS_W'(1);
                        end
                    end else begin
                        state_d   = IDLE;
                        persist_d = '0;
                    end
                end
                DRIVE: begin
                    if ((hold_q + HOLD_W'(1)) >= HOLD_W'(HOLD_TICKS)) begin
                        state_d = HOLD;
                        hold_d  = '0;
                        clr_d   = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                HOLD: begin
                    // Release needs CLEAR_TICKS consecutive ticks with the pedal flag low.
                    if (act[PRIMARY_CH]) begin
                        clr_d = '0;
                    end else if ((clr_q + CLR_W'(1)) >= CLR_W'(CLEAR_TICKS)) begin
                        state_d = IDLE;
                        clr_d   = '0;
                    end else begin
                        clr_d = clr_q + CLR_W'(1);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    persist_d = '0;
                    hold_d    = '0;
                    clr_d     = '0;
                end
            endcase
        end

        drive_d     = (state_d == DRIVE) || (state_d == HOLD);
        // Event set dominates a coincident clear.
        pm_d        = event_c ? 1'b1 : (bus.pm_clr ? 1'b0 : pm_q);
        event_cnt_d = (event_c && (event_cnt_q != 16'hFFFF)) ? (event_cnt_q + 16'd1)
                                                              : event_cnt_q;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            persist_q   <= '0;
            hold_q      <= '0;
            clr_q       <= '0;
            drive_q     <= 1'b0;
            pm_q        <= 1'b0;
            event_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            persist_q   <= persist_d;
            hold_q      <= hold_d;
            clr_q       <= clr_d;
            drive_q     <= drive_d;
            pm_q        <= pm_d;
            event_cnt_q <= event_cnt_d;
        end
    end

    assign bus.drive     = drive_q;
    assign bus.pm        = pm_q;
    assign bus.state     = 3'(state_q);
    assign bus.score     = score;
    assign bus.event_cnt = event_cnt_q;

endmodule

// File: tb/tb_pmpd_arbiter.sv
// Directed bench for pmpd_arbiter with an expectation queue.
module tb_pmpd_arbiter;
    import pmpd_pkg::*;

    typedef struct {
        string       tag;
        logic        drive;
        logic        pm;
        logic [2:0]  state;
        logic [15:0] cnt;
        bit          chk_score;
        logic [5:0]  score;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic        exp_pm;
    logic [15:0] exp_cnt;
    exp_t        exp_q[$];

    pmpd_arbiter_if #(.N_CH(4), .W_WIDTH(4)) bus ();

    pmpd_arbiter #(
        .N_CH          (4),
        .W_WIDTH       (4),
        .PRIMARY_CH    (0),
        .PERSIST_TICKS (3),
        .HOLD_TICKS    (20),
        .CLEAR_TICKS   (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick1();
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick1();
    endtask

    task automatic push(input string tag, input logic d, input logic [2:0] st,
                        input bit cs = 1'b0, input logic [5:0] sc = 6'd0);
        exp_t e;
        e.tag = tag; e.drive = d; e.pm = exp_pm; e.state = st;
        e.cnt = exp_cnt; e.chk_score = cs; e.score = sc;
        exp_q.push_back(e);
    endtask

    task automatic cmp();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty got 0 entries exp 1");
            return;
        end
        e = exp_q.pop_front();
        checks++;
        assert (bus.drive === e.drive) else begin
            errors++;
            $error("FAIL %s drive got %0b exp %0b", e.tag, bus.drive, e.drive);
        end
        checks++;
        assert (bus.pm === e.pm) else begin
            errors++;
            $error("FAIL %s pm got %0b exp %0b", e.tag, bus.pm, e.pm);
        end
        checks++;
        assert (bus.state === e.state) else begin
            errors++;
            $error("FAIL %s state got %0d exp %0d", e.tag, bus.state, e.state);
        end
        checks++;
        assert (bus.event_cnt === e.cnt) else begin
            errors++;
            $error("FAIL %s event_cnt got %h exp %h", e.tag, bus.event_cnt, e.cnt);
        end
        if (e.chk_score) begin
            checks++;
            assert (bus.score === e.score) else begin
                errors++;
                $error("FAIL %s score got %0d exp %0d", e.tag, bus.score, e.score);
            end
        end
    endtask

    // Three qualifying ticks from IDLE: ARMED, ARMED, then DRIVE with an event.
    task automatic fire(input string tag);
        push({tag, "_arm1"}, 1'b0, ARMED);
        tick1(); cmp();
        push({tag, "_arm2"}, 1'b0, ARMED);
        tick1(); cmp();
        exp_pm = 1'b1;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        push({tag, "_drive"}, 1'b1, DRIVE);
        tick1(); cmp();
    endtask

    task automatic cancel_pulse(input string tag);
        push(tag, 1'b0, IDLE);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        cmp();
    endtask

    initial begin
        checks = 0; errors = 0;
        exp_pm = 1'b0; exp_cnt = 16'd0;
        rst = 1'b1;
        bus.tick = 1'b0; bus.flags = 4'b0000; bus.ch_en = 4'b1111;
        bus.weights = 16'h4321; bus.threshold = 6'd5;
        bus.mode = MODE_PRIMARY_PLUS; bus.cancel = 1'b0; bus.pm_clr = 1'b0;
        cyc(2);
        push("reset", 1'b0, IDLE, 1'b1, 6'd0);
        cmp();
        rst = 1'b0;
        cyc(1);

        // PRIMARY_PLUS fire, hold and clean release
        bus.flags = 4'b0011;
        push("pp_score", 1'b0, IDLE, 1'b1, 6'd3);
        cyc(1); cmp();
        fire("pp");
        bus.flags = 4'b0000;
        push("pp_drive19", 1'b1, DRIVE);
        ticks(19); cmp();
        push("pp_hold20", 1'b1, HOLD);
        tick1(); cmp();
        push("pp_hold24", 1'b1, HOLD);
        ticks(4); cmp();
        push("pp_release25", 1'b0, IDLE);
        tick1(); cmp();

        // MAJORITY
        bus.mode = MODE_MAJORITY; bus.ch_en = 4'b1110; bus.flags = 4'b0110;
        cyc(1);
        fire("maj");
        cancel_pulse("maj_cancel");
        bus.flags = 4'b0010;
        cyc(1);
        push("maj_minority", 1'b0, IDLE);
        ticks(4); cmp();
        bus.ch_en = 4'b0000; bus.flags = 4'b1111;
        cyc(1);
        push("maj_no_en", 1'b0, IDLE, 1'b1, 6'd0);
        ticks(4); cmp();

        // WEIGHTED
        bus.mode = MODE_WEIGHTED; bus.ch_en = 4'b1111; bus.flags = 4'b1001;
        push("w1001_score", 1'b0, IDLE, 1'b1, 6'd5);
        cyc(1); cmp();
        fire("w1001");
        cancel_pulse("w1001_cancel");
        bus.flags = 4'b0110;
        push("w0110_score", 1'b0, IDLE, 1'b1, 6'd5);
        cyc(1); cmp();
        fire("w0110");
        cancel_pulse("w0110_cancel");
        bus.flags = 4'b0101;
        push("w0101_score", 1'b0, IDLE, 1'b1, 6'd4);
        cyc(1); cmp();
        push("w0101_nofire", 1'b0, IDLE);
        ticks(4); cmp();
        bus.threshold = 6'd0; bus.flags = 4'b1111;
        cyc(1);
        push("w_thr0", 1'b0, IDLE, 1'b1, 6'd10);
        ticks(4); cmp();
        bus.threshold = 6'd5;

        // Cancel during HOLD, no re-arm while held, re-arm after release
        bus.mode = MODE_PRIMARY_PLUS; bus.flags = 4'b0011;
        cyc(1);
        fire("ch");
        push("ch_hold", 1'b1, HOLD);
        ticks(20); cmp();
        push("ch_cancel", 1'b0, IDLE);
        bus.cancel = 1'b1;
        @(negedge clk); cmp();
        push("ch_cancel_held", 1'b0, IDLE);
        ticks(4); cmp();
        bus.cancel = 1'b0;
        fire("ch_rearm");
        bus.mode = MODE_OFF;
        push("off_drop", 1'b0, IDLE);
        cyc(1); cmp();
        bus.flags = 4'b0000; bus.mode = MODE_PRIMARY_PLUS;
        cyc(1);

        // pm_clr alone
        exp_pm = 1'b0;
        push("pm_clr", 1'b0, IDLE);
        bus.pm_clr = 1'b1;
        @(negedge clk);
        bus.pm_clr = 1'b0;
        cmp();

        // Cond drops in ARMED: no event
        bus.flags = 4'b0011;
        cyc(1);
        push("abort_arm", 1'b0, ARMED);
        tick1(); cmp();
        bus.flags = 4'b0000;
        cyc(1);
        push("abort_idle", 1'b0, IDLE);
        tick1(); cmp();

        // pm_clr coincident with event: set wins
        bus.flags = 4'b0011;
        cyc(1);
        push("coinc_arm1", 1'b0, ARMED);
        tick1(); cmp();
        push("coinc_arm2", 1'b0, ARMED);
        tick1(); cmp();
        exp_pm = 1'b1; exp_cnt = exp_cnt + 16'd1;
        push("coinc_event", 1'b1, DRIVE);
        bus.pm_clr = 1'b1;
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0; bus.pm_clr = 1'b0;
        cmp();
        cancel_pulse("coinc_cancel");

        // Saturation: preload the counter near the top, then fire twice
        force dut.event_cnt_q = 16'hFFFE;
        cyc(1);
        release dut.event_cnt_q;
        exp_cnt = 16'hFFFE;
        push("sat_preload", 1'b0, IDLE);
        cyc(1); cmp();
        fire("sat1");
        cancel_pulse("sat1_cancel");
        fire("sat2");

        // Async reset mid-DRIVE
        exp_pm = 1'b0; exp_cnt = 16'd0;
        push("rst_mid_drive", 1'b0, IDLE, 1'b1, 6'd0);
        rst = 1'b1;
        #1;
        cmp();
        @(negedge clk);
        rst = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
